inst_memory: RTL and testbench

INST_MEMORY -- requirements
Module: inst_memory

---
 rtl/inst_memory_pkg.sv | 36 +++
 rtl/inst_byte_assembler.sv | 67 ++++++
 rtl/inst_memory.sv | 88 ++++++++
 tb/tb_inst_memory.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/inst_memory_pkg.sv
// -----------------------------------------------------------------------------
// inst_memory_pkg
// Shared constants and types for the instruction memory and its byte loader.
//   BYTES_PER_INST : bytes per instruction word
//   INST_W         : instruction word width in bits
//   byte_idx_t     : index of a byte within an instruction word (0 = MSB)
//   insert_byte()  : place one byte into a word at its big-endian position
// -----------------------------------------------------------------------------
package inst_memory_pkg;

   localparam int BYTES_PER_INST = 4;
   localparam int INST_W         = 32;

   typedef logic [1:0] byte_idx_t;

   localparam byte_idx_t LAST_BYTE_IDX = byte_idx_t'(BYTES_PER_INST - 1);

   // Byte 0 is the most significant byte: the first byte received from the
   // loader ends up in bits [31:24].
   function automatic logic [INST_W-1:0] insert_byte(
      input logic [INST_W-1:0] word,
      input byte_idx_t         idx,
      input logic [7:0]        data
   );
      logic [INST_W-1:0] result;
      result = word;
      case (idx)
         2'd0:    result[31:24] = data;
         2'd1:    result[23:16] = data;
         2'd2:    result[15:8]  = data;
         default: result[7:0]   = data;
      endcase
      return result;
   endfunction

endpackage : inst_memory_pkg

// File: rtl/inst_byte_assembler.sv
// -----------------------------------------------------------------------------
// inst_byte_assembler
// Collects loader bytes into big-endian 32-bit instruction words.
// Ports:
//   clk_i        : clock, all state updates on the rising edge
//   rst_ni       : synchronous active-low reset
//   byte_i       : incoming program byte
//   strobe_i     : byte-valid strobe, one byte accepted per high cycle
//   enable_i     : load mode; low holds the assembler idle and discards
//                  any partially collected word
//   word_valid_o : high in the cycle the fourth byte is accepted
//   word_o       : completed word, meaningful while word_valid_o is high
// -----------------------------------------------------------------------------
module inst_byte_assembler
   import inst_memory_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [7:0]        byte_i,
   input  logic              strobe_i,
   input  logic              enable_i,
   output logic              word_valid_o,
   output logic [INST_W-1:0] word_o
);

   byte_idx_t         cnt_q, cnt_d;
   logic [INST_W-1:0] asm_q, asm_d;
   logic              accept;
   logic              last_byte;

   assign accept    = enable_i && strobe_i;
   assign last_byte = (cnt_q == LAST_BYTE_IDX);

   // The completed word is formed combinationally so it can be written to
   // memory in the same cycle the fourth byte arrives.
   assign word_o = insert_byte(asm_q, cnt_q, byte_i);

   // A byte strobed during reset must never reach memory.
   assign word_valid_o = rst_ni && accept && last_byte;

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred; blocking '='
      // belongs here, non-blocking '<=' only in clocked blocks.
      cnt_d = cnt_q;
      asm_d = asm_q;
      if (!enable_i) begin
         cnt_d = '0;
         asm_d = '0;
      end else if (strobe_i) begin
         // Counter is two bits wide, so it returns to 0 after the fourth byte.
         cnt_d = cnt_q + 2'd1;
         asm_d = last_byte ? '0 : word_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         asm_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         asm_q <= asm_d;
      end
   end

endmodule : inst_byte_assembler

// File: rtl/inst_memory.sv
// -----------------------------------------------------------------------------
// inst_memory
// Instruction memory filled byte-by-byte by an external loader and read
// through a registered fetch port.
// Parameters:
//   INST_MEM_WIDTH : word-address width; depth is 2**INST_MEM_WIDTH words
// Ports:
//   CLK           : clock, all state updates on the rising edge
//   reset         : synchronous active-low reset
//   pc            : word address to fetch (used directly as the word index)
//   loader_data   : program byte from the loader
//   loader_enable : high = load mode, low = fetch mode
//   loader_ready  : byte-valid strobe for loader_data
//   inst          : fetched instruction, one cycle after pc is presented
// -----------------------------------------------------------------------------
module inst_memory
   import inst_memory_pkg::*;
#(
   parameter int INST_MEM_WIDTH = 2
) (
   input  logic                      CLK,
   input  logic                      reset,
   input  logic [INST_MEM_WIDTH-1:0] pc,
   input  logic [7:0]                loader_data,
   input  logic                      loader_enable,
   input  logic                      loader_ready,
   output logic [INST_W-1:0]         inst
);

   localparam int DEPTH = 2 ** INST_MEM_WIDTH;

   logic [INST_W-1:0]         mem_q [DEPTH];
   logic [INST_MEM_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [INST_W-1:0]         inst_q;
   logic                      word_valid;
   logic [INST_W-1:0]         word;

   inst_byte_assembler u_assembler (
      .clk_i        (CLK),
      .rst_ni       (reset),
      .byte_i       (loader_data),
      .strobe_i     (loader_ready),
      .enable_i     (loader_enable),
      .word_valid_o (word_valid),
      .word_o       (word)
   );

   // Each load session starts at word 0; the pointer wraps naturally at the
   // top of the array, so later words overwrite the oldest ones.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      if (!loader_enable) begin
         wr_ptr_d = '0;
      end else if (word_valid) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!reset) begin
         wr_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // NOTE: the memory array is deliberately left out of reset; clearing it
   // would prevent block-RAM inference, and its contents are undefined until
   // the loader writes them.
   always_ff @(posedge CLK) begin
      if (word_valid) begin
         mem_q[wr_ptr_q] <= word;
      end
   end

   // Registered read. With non-blocking updates a same-address write in the
   // same cycle is not yet visible, giving read-before-write behaviour.
   always_ff @(posedge CLK) begin
      if (!reset) begin
         inst_q <= '0;
      end else begin
         inst_q <= mem_q[pc];
      end
   end

   assign inst = inst_q;

endmodule : inst_memory

// File: tb/tb_inst_memory.sv
// -----------------------------------------------------------------------------
// tb_inst_memory
// Directed self-checking bench for inst_memory (INST_MEM_WIDTH = 2).
// -----------------------------------------------------------------------------
module tb_inst_memory;

   localparam int AW = 2;

   logic          CLK;
   logic          reset;
   logic [AW-1:0] pc;
   logic [7:0]    loader_data;
   logic          loader_enable;
   logic          loader_ready;
   logic [31:0]   inst;

   int checks = 0;
   int errors = 0;

   inst_memory #(.INST_MEM_WIDTH(AW)) dut (
      .CLK           (CLK),
      .reset         (reset),
      .pc            (pc),
      .loader_data   (loader_data),
      .loader_enable (loader_enable),
      .loader_ready  (loader_ready),
      .inst          (inst)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 time unit past it.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      loader_data  = b;
      loader_ready = 1'b1;
      tick();
      loader_ready = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic fetch(input logic [AW-1:0] addr, input logic [31:0] exp, input string tag);
      pc = addr;
      tick();
      check(tag, inst, exp);
   endtask

   localparam logic [31:0] W0 = 32'h01020304;
   localparam logic [31:0] W1 = 32'h11121314;
   localparam logic [31:0] W2 = 32'h21222324;
   localparam logic [31:0] W3 = 32'h31323334;
   localparam logic [31:0] W4 = 32'h41424344;

   initial begin
      reset         = 1'b0;
      pc            = '0;
      loader_data   = 8'h00;
      loader_enable = 1'b0;
      loader_ready  = 1'b0;

      // Reset held for two cycles.
      tick();
      tick();
      check("reset_inst", inst, 32'h0);
      reset = 1'b1;

      // First word with idle gaps between bytes; lands at address 0.
      loader_enable = 1'b1;
      send_byte(8'h04);
      tick();
      send_byte(8'h10);
      tick();
      tick();
      send_byte(8'hC2);
      send_byte(8'h00);
      loader_enable = 1'b0;
      fetch(2'd0, 32'h0410C200, "first_word_addr0");

      // Two words in one session.
      loader_enable = 1'b1;
      send_word(32'h0410C200);
      send_word(32'h58046500);
      loader_enable = 1'b0;
      fetch(2'd1, 32'h58046500, "two_words_pc1");
      fetch(2'd0, 32'h0410C200, "two_words_pc0");

      // Five words into a four-word memory: W4 overwrites W0.
      loader_enable = 1'b1;
      send_word(W0);
      send_word(W1);
      send_word(W2);
      send_word(W3);
      send_word(W4);
      loader_enable = 1'b0;
      fetch(2'd0, W4, "wrap_pc0");
      fetch(2'd1, W1, "wrap_pc1");
      fetch(2'd2, W2, "wrap_pc2");
      fetch(2'd3, W3, "wrap_pc3");

      // Partial word then disable: memory unchanged, next session restarts.
      pc            = 2'd0;
      loader_enable = 1'b1;
      send_byte(8'hAA);
      send_byte(8'hBB);
      loader_enable = 1'b0;
      tick();
      check("partial_discard_pc0", inst, W4);
      loader_enable = 1'b1;
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      // Same-cycle write and read of address 0: old contents visible.
      check("read_before_write", inst, W4);
      tick();
      check("reload_load_mode_fetch", inst, 32'h11223344);
      loader_enable = 1'b0;
      fetch(2'd1, W1, "partial_no_write_pc1");

      // Strobes in fetch mode are ignored.
      send_byte(8'hDE);
      send_byte(8'hAD);
      send_byte(8'hBE);
      send_byte(8'hEF);
      fetch(2'd0, 32'h11223344, "ignored_strobes_pc0");
      fetch(2'd1, W1, "ignored_strobes_pc1");

      // Reset after three bytes: those bytes and the reset-cycle byte are lost.
      loader_enable = 1'b1;
      send_byte(8'h99);
      send_byte(8'h88);
      send_byte(8'h77);
      reset        = 1'b0;
      pc           = 2'd1;
      loader_data  = 8'h66;
      loader_ready = 1'b1;
      tick();
      check("midword_reset_inst", inst, 32'h0);
      reset        = 1'b1;
      loader_ready = 1'b0;
      send_word(32'hCAFEBABE);
      loader_enable = 1'b0;
      fetch(2'd0, 32'hCAFEBABE, "after_reset_pc0");
      fetch(2'd1, W1, "after_reset_pc1");
      fetch(2'd2, W2, "after_reset_pc2");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_inst_memory
